// File: rtl/vdp_pkg.sv
// rtl/vdp_pkg.sv - shared constants, FSM state type and status packing for the VDP port
package vdp_pkg;

  localparam int NUM_REGS_DEF = 11;
  localparam int VRAM_AW_DEF  = 14;
  localparam int CRAM_AW_DEF  = 5;

  localparam logic [1:0] CODE_VRD  = 2'd0;
  localparam logic [1:0] CODE_VWR  = 2'd1;
  localparam logic [1:0] CODE_REG  = 2'd2;
  localparam logic [1:0] CODE_CRAM = 2'd3;

  localparam logic PORT_DATA = 1'b0;
  localparam logic PORT_CTRL = 1'b1;

  localparam int STAT_FRAME = 7;
  localparam int STAT_OVF   = 6;
  localparam int STAT_COLL  = 5;

  typedef enum logic [1:0] {
    PF_IDLE,
    PF_RD,
    PF_CAP
  } pf_state_t;

  // Low five bits report the overflowing sprite only while the overflow flag is up.
  function automatic logic [7:0] status_byte(input logic frame_f, input logic ovf_f,
                                             input logic coll_f, input logic [4:0] sprite5);
    logic [7:0] s;
    s = {3'b000, (ovf_f ? sprite5 : 5'h1F)};
    s[STAT_FRAME] = frame_f;
    s[STAT_OVF]   = ovf_f;
    s[STAT_COLL]  = coll_f;
    return s;
  endfunction

endpackage

// File: rtl/vdp_line_counter.sv
// rtl/vdp_line_counter.sv - reloadable down-counter that raises the line interrupt flag
module vdp_line_counter (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_start,
  input  logic       line_tick,
  input  logic [7:0] reload,
  input  logic       clr,
  output logic       line_f
);

  logic [7:0] line_cnt;
  logic       line_set;

  assign line_set = line_tick & ~frame_start & (line_cnt == 8'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_cnt <= 8'd0;
      line_f   <= 1'b0;
    end else begin
      if (frame_start) begin
        line_cnt <= reload;
      end else if (line_tick) begin
        line_cnt <= (line_cnt == 8'd0) ? reload : line_cnt - 8'd1;
      end
      // A set arriving in the clearing cycle keeps the flag high.
      line_f <= line_set | (line_f & ~clr);
    end
  end

endmodule

// File: rtl/vdp_port.sv
// rtl/vdp_port.sv - CPU data/control port responder: address latch, registers, prefetch, status, interrupt
import vdp_pkg::*;

module vdp_port #(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int VRAM_AW  = VRAM_AW_DEF,
  parameter int CRAM_AW  = CRAM_AW_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  io_cs,
  input  logic                  io_wr,
  input  logic                  io_port,
  input  logic [7:0]            io_din,
  output logic [7:0]            io_dout,
  output logic [VRAM_AW-1:0]    vram_addr,
  output logic                  vram_we,
  output logic [7:0]            vram_wdata,
  output logic                  vram_re,
  input  logic [7:0]            vram_rdata,
  output logic [CRAM_AW-1:0]    cram_addr,
  output logic                  cram_we,
  output logic [5:0]            cram_wdata,
  output logic [8*NUM_REGS-1:0] regs,
  input  logic                  frame_set,
  input  logic                  coll_set,
  input  logic                  ovf_set,
  input  logic [4:0]            sprite5,
  input  logic                  frame_start,
  input  logic                  line_tick,
  output logic                  int_n
);

  logic               latch;
  logic [7:0]         first;
  logic [1:0]         code;
  logic [VRAM_AW-1:0] addr;
  logic [7:0]         buffer;
  logic [7:0]         regs_q [NUM_REGS];
  pf_state_t          state;
  logic               frame_f, ovf_f, coll_f, line_f;

  logic ctrl_wr, ctrl_rd, data_wr, data_rd;

  assign ctrl_wr = io_cs &  io_wr & (io_port == PORT_CTRL);
  assign ctrl_rd = io_cs & ~io_wr & (io_port == PORT_CTRL);
  assign data_wr = io_cs &  io_wr & (io_port == PORT_DATA);
  assign data_rd = io_cs & ~io_wr & (io_port == PORT_DATA);

  assign io_dout   = (io_port == PORT_CTRL) ? status_byte(frame_f, ovf_f, coll_f, sprite5) : buffer;
  assign vram_addr = addr;
  assign cram_addr = addr[CRAM_AW-1:0];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs[8*g +: 8] = regs_q[g];
  end

  // Strobes are registered, so the address advances in the cycle the strobe is seen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      latch      <= 1'b0;
      first      <= 8'h00;
      code       <= CODE_VRD;
      addr       <= '0;
      buffer     <= 8'h00;
      state      <= PF_IDLE;
      vram_we    <= 1'b0;
      vram_re    <= 1'b0;
      vram_wdata <= 8'h00;
      cram_we    <= 1'b0;
      cram_wdata <= 6'h00;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
    end else begin
      vram_we <= 1'b0;
      vram_re <= 1'b0;
      cram_we <= 1'b0;
      if (vram_we || cram_we) addr <= addr + 1'b1;

      case (state)
        PF_RD:   state <= PF_CAP;
        PF_CAP: begin
          buffer <= vram_rdata;
          addr   <= addr + 1'b1;
          state  <= PF_IDLE;
        end
        default: state <= PF_IDLE;
      endcase

      if (ctrl_wr) begin
        if (!latch) begin
          addr[7:0] <= io_din;
          first     <= io_din;
          latch     <= 1'b1;
        end else begin
          latch <= 1'b0;
          code  <= io_din[7:6];
          addr  <= VRAM_AW'({io_din[5:0], first});
          if (io_din[7:6] == CODE_VRD) begin
            vram_re <= 1'b1;
            state   <= PF_RD;
          end
          if (io_din[7:6] == CODE_REG) begin
            for (int i = 0; i < NUM_REGS; i++)
              if (int'(io_din[3:0]) == i) regs_q[i] <= first;
          end
        end
      end

      if (data_wr) begin
        latch  <= 1'b0;
        buffer <= io_din;
        if (code == CODE_CRAM) begin
          cram_we    <= 1'b1;
          cram_wdata <= io_din[5:0];
        end else begin
          vram_we    <= 1'b1;
          vram_wdata <= io_din;
        end
      end

      if (data_rd) begin
        latch   <= 1'b0;
        vram_re <= 1'b1;
        state   <= PF_RD;
      end

      if (ctrl_rd) latch <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_f <= 1'b0;
      ovf_f   <= 1'b0;
      coll_f  <= 1'b0;
      int_n   <= 1'b1;
    end else begin
      frame_f <= frame_set | (frame_f & ~ctrl_rd);
      ovf_f   <= ovf_set   | (ovf_f   & ~ctrl_rd);
      coll_f  <= coll_set  | (coll_f  & ~ctrl_rd);
      int_n   <= ~((frame_f & regs_q[1][5]) | (line_f & regs_q[0][4]));
    end
  end

  vdp_line_counter u_line (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .line_tick   (line_tick),
    .reload      (regs_q[10]),
    .clr         (ctrl_rd),
    .line_f      (line_f)
  );

endmodule

// File: tb/tb_vdp_port.sv
// tb/tb_vdp_port.sv - directed self-checking bench for vdp_port
module tb_vdp_port;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        io_cs = 1'b0, io_wr = 1'b0, io_port = 1'b0;
  logic [7:0]  io_din = 8'h00;
  logic [7:0]  io_dout;
  logic [13:0] vram_addr;
  logic        vram_we, vram_re;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata = 8'h00;
  logic [4:0]  cram_addr;
  logic        cram_we;
  logic [5:0]  cram_wdata;
  logic [87:0] regs;
  logic        frame_set = 1'b0, coll_set = 1'b0, ovf_set = 1'b0;
  logic [4:0]  sprite5 = 5'h00;
  logic        frame_start = 1'b0, line_tick = 1'b0;
  logic        int_n;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0]  mem [0:16383];
  int          wr_count = 0, re_count = 0, cram_count = 0, overlap_count = 0;
  logic [13:0] last_wr_addr = '0, last_re_addr = '0;
  logic [7:0]  last_wr_data = '0;
  logic [4:0]  last_cram_addr = '0;
  logic [5:0]  last_cram_data = '0;

  vdp_port dut (
    .clk(clk), .reset_n(reset_n), .io_cs(io_cs), .io_wr(io_wr), .io_port(io_port),
    .io_din(io_din), .io_dout(io_dout), .vram_addr(vram_addr), .vram_we(vram_we),
    .vram_wdata(vram_wdata), .vram_re(vram_re), .vram_rdata(vram_rdata),
    .cram_addr(cram_addr), .cram_we(cram_we), .cram_wdata(cram_wdata), .regs(regs),
    .frame_set(frame_set), .coll_set(coll_set), .ovf_set(ovf_set), .sprite5(sprite5),
    .frame_start(frame_start), .line_tick(line_tick), .int_n(int_n)
  );

  always #5 clk = ~clk;

  // VRAM model with a one-clock read latency, plus strobe logging.
  always @(posedge clk) begin
    if (vram_we) begin
      mem[vram_addr] <= vram_wdata;
      wr_count       <= wr_count + 1;
      last_wr_addr   <= vram_addr;
      last_wr_data   <= vram_wdata;
    end
    if (vram_re) begin
      vram_rdata   <= mem[vram_addr];
      re_count     <= re_count + 1;
      last_re_addr <= vram_addr;
    end
    if (cram_we) begin
      cram_count     <= cram_count + 1;
      last_cram_addr <= cram_addr;
      last_cram_data <= cram_wdata;
    end
    if (vram_we && vram_re) overlap_count <= overlap_count + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic wr, input logic port, input logic [7:0] din,
                        output logic [7:0] dout);
    @(negedge clk);
    io_cs = 1'b1; io_wr = wr; io_port = port; io_din = din;
    #1 dout = io_dout;
    @(negedge clk);
    io_cs = 1'b0; io_wr = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic cwr(input logic [7:0] d);
    logic [7:0] x;
    access(1'b1, 1'b1, d, x);
  endtask

  task automatic dwr(input logic [7:0] d);
    logic [7:0] x;
    access(1'b1, 1'b0, d, x);
  endtask

  task automatic peek(input logic port, output logic [7:0] d);
    io_port = port;
    #1 d = io_dout;
  endtask

  task automatic pulse(input logic fs, input logic cs, input logic os,
                       input logic fst, input logic lt);
    @(negedge clk);
    frame_set = fs; coll_set = cs; ovf_set = os; frame_start = fst; line_tick = lt;
    @(negedge clk);
    frame_set = 1'b0; coll_set = 1'b0; ovf_set = 1'b0; frame_start = 1'b0; line_tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [7:0] d;

    repeat (3) @(negedge clk);
    peek(1'b0, d);            chk("rst_buffer", d, 8'h00);
    peek(1'b1, d);            chk("rst_status", d, 8'h1F);
    chk("rst_int_n", int_n, 1'b1);
    chk("rst_regs_lo", regs[31:0], 32'h0);
    chk("rst_regs_hi", regs[87:80], 8'h00);
    chk("rst_strobes", {vram_we, vram_re, cram_we}, 3'b000);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // VRAM write sequence at 0x0000.
    cwr(8'h00); cwr(8'h40); dwr(8'hAA); dwr(8'hBB);
    chk("wr_mem0", mem[0], 8'hAA);
    chk("wr_mem1", mem[1], 8'hBB);
    chk("wr_count", wr_count, 2);
    chk("wr_no_re", re_count, 0);
    peek(1'b0, d);            chk("wr_buffer", d, 8'hBB);

    // Register writes, including an out-of-range index.
    cwr(8'h60); cwr(8'h81);
    chk("reg_r1", regs[15:8], 8'h60);
    chk("reg_r0", regs[7:0], 8'h00);
    chk("reg_no_strobe", wr_count + re_count, 2);
    cwr(8'h12); cwr(8'h8F);
    chk("reg_ignored_lo", regs[31:0], 32'h0000_6000);
    chk("reg_ignored_hi", regs[87:80], 8'h00);

    // Read-ahead through the prefetch path.
    cwr(8'h34); cwr(8'h52); dwr(8'h5A); dwr(8'h5B);
    cwr(8'h34); cwr(8'h12);
    chk("pf_re_count", re_count, 1);
    chk("pf_re_addr", last_re_addr, 14'h1234);
    access(1'b0, 1'b0, 8'h00, d);
    chk("rd1_data", d, 8'h5A);
    chk("rd1_re_addr", last_re_addr, 14'h1235);
    access(1'b0, 1'b0, 8'h00, d);
    chk("rd2_data", d, 8'h5B);
    chk("rd_no_overlap", overlap_count, 0);

    // Frame interrupt and status clear.
    cwr(8'h20); cwr(8'h81);
    chk("reg_r1_20", regs[15:8], 8'h20);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("frame_int", int_n, 1'b0);
    access(1'b0, 1'b1, 8'h00, d);
    chk("frame_status", d, 8'h9F);
    chk("frame_int_clr", int_n, 1'b1);
    peek(1'b1, d);            chk("status_cleared", d, 8'h1F);

    // Set in the same cycle as the clearing read wins.
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    io_cs = 1'b1; io_wr = 1'b0; io_port = 1'b1; frame_set = 1'b1;
    @(negedge clk);
    io_cs = 1'b0; frame_set = 1'b0;
    repeat (3) @(negedge clk);
    peek(1'b1, d);            chk("set_wins_status", d, 8'h9F);
    chk("set_wins_int", int_n, 1'b0);
    access(1'b0, 1'b1, 8'h00, d);
    chk("set_wins_int_clr", int_n, 1'b1);

    // Overflow/collision status packing.
    sprite5 = 5'h0A;
    pulse(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("ovf_int_quiet", int_n, 1'b1);
    access(1'b0, 1'b1, 8'h00, d);
    chk("ovf_status", d, 8'h6A);
    peek(1'b1, d);            chk("ovf_cleared", d, 8'h1F);

    // Line interrupt: reload 2, fires on the third tick.
    cwr(8'h10); cwr(8'h80); cwr(8'h02); cwr(8'h8A);
    chk("reg_r10", regs[87:80], 8'h02);
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("line_tick2_int", int_n, 1'b1);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("line_tick3_int", int_n, 1'b0);
    access(1'b0, 1'b1, 8'h00, d);
    chk("line_int_clr", int_n, 1'b1);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("line_reload_tick2", int_n, 1'b1);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("line_reload_tick3", int_n, 1'b0);
    access(1'b0, 1'b1, 8'h00, d);

    // frame_start together with line_tick reloads without decrementing.
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("fs_prio_tick2", int_n, 1'b1);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("fs_prio_tick3", int_n, 1'b0);
    access(1'b0, 1'b1, 8'h00, d);

    // Address wrap.
    cwr(8'hFF); cwr(8'h7F); dwr(8'h11);
    chk("wrap_addr_top", last_wr_addr, 14'h3FFF);
    dwr(8'h22);
    chk("wrap_addr_zero", last_wr_addr, 14'h0000);
    chk("wrap_data", last_wr_data, 8'h22);

    // Status read restarts the latch.
    cwr(8'h55);
    access(1'b0, 1'b1, 8'h00, d);
    cwr(8'h66); cwr(8'h40); dwr(8'h77);
    chk("latch_restart_addr", last_wr_addr, 14'h0066);

    // CRAM write.
    cwr(8'h05); cwr(8'hC0); dwr(8'h3F);
    chk("cram_count", cram_count, 1);
    chk("cram_addr", last_cram_addr, 5'h05);
    chk("cram_data", last_cram_data, 6'h3F);
    chk("cram_no_vram", wr_count, 7);
    chk("no_overlap", overlap_count, 0);

    // Reset during a prefetch: no capture afterwards.
    cwr(8'h00);
    @(negedge clk);
    io_cs = 1'b1; io_wr = 1'b1; io_port = 1'b1; io_din = 8'h00;
    @(negedge clk);
    io_cs = 1'b0; io_wr = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    peek(1'b0, d);            chk("rst_mid_pf_buffer", d, 8'h00);
    chk("rst_mid_pf_regs", regs[15:0], 16'h0000);
    chk("rst_mid_pf_int_n", int_n, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vdp_port.md
Name: vdp_port

Overview:
- CPU-facing responder for the VDP I/O ports: the data port (A0=0) and the control port (A0=1).
- Owns the two-byte control latch, 14-bit VRAM address, code register, VDP register file R0..R10, read-ahead buffer, status flags and the frame/line interrupt output.
- Sits between the CPU I/O decode and the VRAM/CRAM of the video renderer.
- The renderer consumes its register outputs and feeds back status events.

Parameters:
- NUM_REGS, 11, number of VDP registers implemented (indices >= NUM_REGS ignored).
- VRAM_AW, 14, VRAM address width.
- CRAM_AW, 5, CRAM address width (low bits of VRAM address).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- io_cs  in  1  one-cycle strobe per CPU port access, already qualified by the CPU clock edge.
- io_wr  in  1  1=write, 0=read; sampled with io_cs.
- io_port  in  1  0=data port, 1=control port.
- io_din  in  8  CPU write data.
- io_dout  out  8  read data, combinational: read buffer for the data port, status for the control port.
- vram_addr  out  VRAM_AW  VRAM address.
- vram_we  out  1  one-cycle VRAM write strobe.
- vram_wdata  out  8  VRAM write data.
- vram_re  out  1  one-cycle VRAM read strobe.
- vram_rdata  in  8  VRAM read data, valid exactly 1 clk after vram_re.
- cram_addr  out  CRAM_AW  CRAM address.
- cram_we  out  1  CRAM write strobe.
- cram_wdata  out  6  CRAM write data.
- regs  out  8*NUM_REGS  flat register file, R0 in bits [7:0].
- frame_set  in  1  pulse at start of vblank.
- coll_set  in  1  sprite-collision pulse.
- ovf_set  in  1  too-many-sprites pulse.
- sprite5  in  5  index of the overflowing sprite.
- frame_start  in  1  pulse, first line of the frame.
- line_tick  in  1  pulse per active line.
- int_n  out  1  active-low interrupt to the CPU.

Behaviour:
- Reset values: regs=0, addr=0, code=0, latch=0, buffer=0, all flags=0, line_cnt=0, all strobes=0, int_n=1.
- Control write, latch=0:
  - addr[7:0]<=io_din; first<=io_din; latch<=1.
- Control write, latch=1:
  - latch<=0; code<=io_din[7:6]; addr<={io_din[5:0], first}.
  - code 0: issue a prefetch (vram_re at the new addr next cycle), then addr<=addr+1.
  - code 2: if io_din[3:0]<NUM_REGS, regs[io_din[3:0]]<=first.
- Data write:
  - latch<=0; buffer<=io_din.
  - code 3: cram_we at addr[CRAM_AW-1:0] with io_din[5:0].
  - otherwise: vram_we at addr.
  - Then addr<=addr+1.
- Data read:
  - io_dout=buffer during the access; latch<=0.
  - Issue vram_re at the current addr; buffer<=vram_rdata 1 clk later; then addr<=addr+1.
- Control read:
  - io_dout={frame_f, ovf_f, coll_f, ovf_f ? sprite5 : 5'h1F}.
  - After the access, frame_f, ovf_f, coll_f, line_f and latch are cleared.
  - A set pulse in the same cycle as the clear wins; the flag stays 1.
- Prefetch FSM:
  - States: IDLE -> RD (vram_re asserted 1 clk) -> CAP (buffer<=vram_rdata) -> IDLE.
  - The address increments in CAP.
  - The CPU cannot issue another access in under 3 clk, so there is no overlap.
  - vram_we and vram_re are never high together.
- Address arithmetic: addr wraps 0x3FFF -> 0x0000 with no carry out.
- Line counter (8 bit):
  - frame_start: line_cnt<=R10.
  - line_tick with line_cnt==0: line_f<=1 and line_cnt<=R10.
  - Other line_tick: line_cnt<=line_cnt-1.
  - frame_start and line_tick together: frame_start wins (reload only, no decrement).
- Interrupt: int_n = ~((frame_f & R1[5]) | (line_f & R0[4])), registered, 1 clk latency.
- Reset asserted mid-prefetch: the FSM returns to IDLE and no capture occurs.

Decomposition:
- Shared package vdp_pkg holds:
  - code constants CODE_VRD=0, CODE_VWR=1, CODE_REG=2, CODE_CRAM=3;
  - port select constants;
  - status bit positions.
- One natural sub-module, vdp_line_counter: the line counter plus line_f.
- Everything else stays in vdp_port.

Test Plan:
- Ctrl 0x00, ctrl 0x40, data 0xAA, data 0xBB -> vram_we at 0x0000=0xAA and 0x0001=0xBB; buffer=0xBB.
- Ctrl 0x60, ctrl 0x81 -> regs R1=0x60, no VRAM strobe. Ctrl 0x12, ctrl 0x8F -> no register changes.
- VRAM[0x1234]=0x5A and [0x1235]=0x5B; ctrl 0x34, ctrl 0x12 -> vram_re at 0x1234. First data read returns 0x5A and issues vram_re 0x1235; second read returns 0x5B.
- R1=0x20, frame_set pulse -> int_n=0. Ctrl read returns 0x9F; int_n=1 after the access. frame_set in the same cycle as the clear -> flag remains 1.
- R0=0x10, R10=2, frame_start then 3 line_ticks -> line_f set on the 3rd tick, int_n=0, line_cnt reloaded to 2.
- Edge cases:
  - Addr 0x3FFF with code 1, data write -> next write goes to 0x0000.
  - Ctrl 0x55, ctrl read, ctrl 0x66 -> latch restarted, addr[7:0]=0x66.
  - Data 0x3F with code 3 -> cram_we, cram_wdata=0x3F.
